// File: rtl/shift_arbiter.sv
// Two-requester front end for a single shared 32-bit barrel shifter.
// Round-robin grant in IDLE; operands are registered before the shift so requesters may change inputs freely.
module barrelshifter32 (
    input  logic [31:0] a,
    input  logic [4:0]  b,
    input  logic [1:0]  aluc,
    output logic [31:0] c
);
    always_comb begin
        case (aluc)
            2'b00:   c = $signed(a) >>> b;
            2'b10:   c = a >> b;
            default: c = a << b;
        endcase
    end
endmodule

module shift_arbiter #(
    parameter int RR_INIT = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [4:0]  req0_b,
    input  logic [1:0]  req0_op,
    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic [31:0] rsp0_data,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [4:0]  req1_b,
    input  logic [1:0]  req1_op,
    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [31:0] rsp1_data,
    output logic        busy,
    output logic        owner
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t      state_q, state_d;
    logic        prio_q, prio_d;
    logic        owner_q, owner_d;
    logic [31:0] a_q, a_d;
    logic [4:0]  b_q, b_d;
    logic [1:0]  op_q, op_d;
    logic        rsp0_valid_q, rsp0_valid_d;
    logic        rsp1_valid_q, rsp1_valid_d;
    logic [31:0] rsp0_data_q, rsp0_data_d;
    logic [31:0] rsp1_data_q, rsp1_data_d;
    logic [31:0] shift_c;
    logic        grant0, grant1;

    // Shifter sees only the captured operands, never the live request ports.
    barrelshifter32 u_shifter (
        .a    (a_q),
        .b    (b_q),
        .aluc (op_q),
        .c    (shift_c)
    );

    assign grant0     = req0_valid && (!req1_valid || !prio_q);
    assign grant1     = req1_valid && (!req0_valid || prio_q);
    assign req0_ready = (state_q == IDLE) && grant0;
    assign req1_ready = (state_q == IDLE) && grant1;

    always_comb begin
        state_d      = state_q;
        prio_d       = prio_q;
        owner_d      = owner_q;
        a_d          = a_q;
        b_d          = b_q;
        op_d         = op_q;
        rsp0_valid_d = rsp0_valid_q;
        rsp1_valid_d = rsp1_valid_q;
        rsp0_data_d  = rsp0_data_q;
        rsp1_data_d  = rsp1_data_q;
        case (state_q)
            IDLE: begin
                if (req0_valid && req0_ready) begin
                    a_d     = req0_a;
                    b_d     = req0_b;
                    op_d    = req0_op;
                    owner_d = 1'b0;
                    prio_d  = 1'b1;
                    state_d = EXEC;
                end else if (req1_valid && req1_ready) begin
                    a_d     = req1_a;
                    b_d     = req1_b;
                    op_d    = req1_op;
                    owner_d = 1'b1;
                    prio_d  = 1'b0;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (owner_q) begin
                    rsp1_data_d  = shift_c;
                    rsp1_valid_d = 1'b1;
                end else begin
                    rsp0_data_d  = shift_c;
                    rsp0_valid_d = 1'b1;
                end
                state_d = RESP;
            end
            RESP: begin
                if (!owner_q && rsp0_ready) begin
                    rsp0_valid_d = 1'b0;
                    state_d      = IDLE;
                end else if (owner_q && rsp1_ready) begin
                    rsp1_valid_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            prio_q       <= 1'(RR_INIT);
            owner_q      <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= '0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp0_data_q  <= '0;
            rsp1_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            prio_q       <= prio_d;
            owner_q      <= owner_d;
            a_q          <= a_d;
            b_q          <= b_d;
            op_q         <= op_d;
            rsp0_valid_q <= rsp0_valid_d;
            rsp1_valid_q <= rsp1_valid_d;
            rsp0_data_q  <= rsp0_data_d;
            rsp1_data_q  <= rsp1_data_d;
        end
    end

    assign rsp0_valid = rsp0_valid_q;
    assign rsp1_valid = rsp1_valid_q;
    assign rsp0_data  = rsp0_data_q;
    assign rsp1_data  = rsp1_data_q;
    assign busy       = (state_q != IDLE);
    assign owner      = owner_q;
endmodule

// File: tb/tb_shift_arbiter.sv
// Directed self-checking bench for shift_arbiter: shift ops, round-robin, backpressure, isolation, mid-op reset.
module tb_shift_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req0_ready, rsp0_valid, rsp0_ready;
    logic        req1_valid, req1_ready, rsp1_valid, rsp1_ready;
    logic [31:0] req0_a, req1_a, rsp0_data, rsp1_data;
    logic [4:0]  req0_b, req1_b;
    logic [1:0]  req0_op, req1_op;
    logic        busy, owner;

    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] last0, last1;

    shift_arbiter #(.RR_INIT(0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_op    (req0_op),
        .rsp0_valid (rsp0_valid),
        .rsp0_ready (rsp0_ready),
        .rsp0_data  (rsp0_data),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_op    (req1_op),
        .rsp1_valid (rsp1_valid),
        .rsp1_ready (rsp1_ready),
        .rsp1_data  (rsp1_data),
        .busy       (busy),
        .owner      (owner)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
            $error("check %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int idx, input logic v, input logic [31:0] a,
                         input logic [4:0] b, input logic [1:0] op);
        if (idx == 0) begin
            req0_valid = v; req0_a = a; req0_b = b; req0_op = op;
        end else begin
            req1_valid = v; req1_a = a; req1_b = b; req1_op = op;
        end
    endtask

    // One uncontended operation with rsp_ready held high by the caller.
    task automatic run1(input int idx, input logic [31:0] a, input logic [4:0] b,
                        input logic [1:0] op, input logic [31:0] exp, input string tag);
        drive(idx, 1'b1, a, b, op);
        #1;
        check({tag, "_ready"}, 32'(idx == 0 ? req0_ready : req1_ready), 32'd1);
        tick();
        drive(idx, 1'b0, a, b, op);
        check({tag, "_busy"}, 32'(busy), 32'd1);
        check({tag, "_owner"}, 32'(owner), 32'(idx));
        tick();
        check({tag, "_valid"}, 32'(idx == 0 ? rsp0_valid : rsp1_valid), 32'd1);
        check({tag, "_other_valid"}, 32'(idx == 0 ? rsp1_valid : rsp0_valid), 32'd0);
        check({tag, "_data"}, idx == 0 ? rsp0_data : rsp1_data, exp);
        tick();
        check({tag, "_done"}, {30'd0, busy, (idx == 0 ? rsp0_valid : rsp1_valid)}, 32'd0);
        $display("op %s: req%0d a=%h b=%0d op=%b -> %h", tag, idx, a, b, op, exp);
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 1'b0, 32'd0, 5'd0, 2'd0);
        drive(1, 1'b0, 32'd0, 5'd0, 2'd0);
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        tick();
        tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_owner", 32'(owner), 32'd0);
        check("rst_valids", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
        check("rst_data0", rsp0_data, 32'd0);
        check("rst_data1", rsp1_data, 32'd0);
        rst_n = 1'b1;
        tick();

        // Single ASR, cycle by cycle.
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        drive(0, 1'b1, 32'h8000_0000, 5'd4, 2'b00);
        #1;
        check("asr_ready0", 32'(req0_ready), 32'd1);
        check("asr_ready1", 32'(req1_ready), 32'd0);
        tick();
        drive(0, 1'b0, 32'h8000_0000, 5'd4, 2'b00);
        check("asr_exec_busy", 32'(busy), 32'd1);
        check("asr_exec_valid", 32'(rsp0_valid), 32'd0);
        check("asr_exec_ready", 32'(req0_ready), 32'd0);
        tick();
        check("asr_resp_valid", 32'(rsp0_valid), 32'd1);
        check("asr_resp_data", rsp0_data, 32'hF800_0000);
        check("asr_resp_busy", 32'(busy), 32'd1);
        tick();
        check("asr_idle_busy", 32'(busy), 32'd0);
        check("asr_idle_valid", 32'(rsp0_valid), 32'd0);
        check("asr_data_kept", rsp0_data, 32'hF800_0000);
        $display("op asr: req0 a=80000000 b=4 op=00 -> f8000000");

        run1(1, 32'h8000_0000, 5'd4,  2'b10, 32'h0800_0000, "lsr");
        run1(1, 32'h0000_0001, 5'd31, 2'b01, 32'h8000_0000, "shl31");
        run1(1, 32'h1234_5678, 5'd0,  2'b11, 32'h1234_5678, "shl0");
        run1(0, 32'h7FFF_FFFF, 5'd31, 2'b00, 32'h0000_0000, "asr_pos");
        run1(0, 32'h8000_0000, 5'd0,  2'b00, 32'h8000_0000, "asr0");
        run1(1, 32'hF0F0_F0F0, 5'd8,  2'b00, 32'hFFF0_F0F0, "asr8");

        // Contention: pointer now favours requester 0.
        last0 = 32'h8000_0000;
        last1 = 32'hFFF0_F0F0;
        drive(0, 1'b1, 32'h0000_FF00, 5'd8, 2'b10);
        drive(1, 1'b1, 32'h0000_FF00, 5'd4, 2'b01);
        for (int k = 0; k < 4; k++) begin
            #1;
            check($sformatf("rr%0d_ready0", k), 32'(req0_ready), 32'(k % 2 == 0));
            check($sformatf("rr%0d_ready1", k), 32'(req1_ready), 32'(k % 2 == 1));
            tick();
            check($sformatf("rr%0d_owner", k), 32'(owner), 32'(k % 2));
            tick();
            if (k % 2 == 0) begin
                last0 = 32'h0000_00FF;
                check($sformatf("rr%0d_valid", k), {30'd0, rsp1_valid, rsp0_valid}, 32'd1);
            end else begin
                last1 = 32'h000F_F000;
                check($sformatf("rr%0d_valid", k), {30'd0, rsp1_valid, rsp0_valid}, 32'd2);
            end
            check($sformatf("rr%0d_data0", k), rsp0_data, last0);
            check($sformatf("rr%0d_data1", k), rsp1_data, last1);
            tick();
            $display("op rr%0d: grant %0d data0=%h data1=%h", k, k % 2, rsp0_data, rsp1_data);
        end
        drive(0, 1'b0, 32'h0, 5'd0, 2'd0);
        drive(1, 1'b0, 32'h0, 5'd0, 2'd0);

        // Backpressure on rsp0 while req1 waits.
        rsp0_ready = 1'b0;
        drive(0, 1'b1, 32'hAAAA_5555, 5'd1, 2'b11);
        drive(1, 1'b1, 32'h0000_0010, 5'd4, 2'b10);
        #1;
        check("bp_grant0", {30'd0, req1_ready, req0_ready}, 32'd1);
        tick();
        req0_valid = 1'b0;
        tick();
        for (int k = 0; k < 5; k++) begin
            check($sformatf("bp%0d_valid", k), 32'(rsp0_valid), 32'd1);
            check($sformatf("bp%0d_data", k), rsp0_data, 32'h5554_AAAA);
            check($sformatf("bp%0d_req1_ready", k), 32'(req1_ready), 32'd0);
            tick();
        end
        rsp0_ready = 1'b1;
        #1;
        check("bp_hs_req1_ready", 32'(req1_ready), 32'd0);
        tick();
        rsp0_ready = 1'b0;
        check("bp_after_valid", 32'(rsp0_valid), 32'd0);
        check("bp_after_req1_ready", 32'(req1_ready), 32'd1);
        tick();
        req1_valid = 1'b0;
        check("bp_req1_owner", 32'(owner), 32'd1);
        tick();
        check("bp_req1_data", rsp1_data, 32'h0000_0001);
        check("bp_rsp0_idle", 32'(rsp0_valid), 32'd0);
        tick();
        $display("op backpressure: rsp0=5554aaaa held 5 cycles, then req1 -> 00000001");

        // Input isolation: operands change after the accept edge.
        rsp0_ready = 1'b1;
        drive(0, 1'b1, 32'h0000_00F0, 5'd4, 2'b10);
        tick();
        drive(0, 1'b0, 32'hFFFF_FFFF, 5'd0, 2'b11);
        tick();
        drive(0, 1'b0, 32'h1111_1111, 5'd1, 2'b01);
        check("iso_data", rsp0_data, 32'h0000_000F);
        tick();
        $display("op isolation: req0 a=000000f0 b=4 op=10 -> 0000000f");

        // Mid-op reset: this grant leaves the pointer at 1 unless reset restores it.
        drive(0, 1'b1, 32'h0000_0001, 5'd1, 2'b01);
        tick();
        req0_valid = 1'b0;
        check("mid_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_valids", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
        check("mid_rst_data0", rsp0_data, 32'd0);
        check("mid_rst_data1", rsp1_data, 32'd0);
        check("mid_rst_owner", 32'(owner), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("mid_post%0d", k), {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
        end
        drive(0, 1'b1, 32'h0000_0001, 5'd1, 2'b01);
        drive(1, 1'b1, 32'h0000_0004, 5'd1, 2'b10);
        #1;
        check("mid_regrant", {30'd0, req1_ready, req0_ready}, 32'd1);
        tick();
        drive(0, 1'b0, 32'h0, 5'd0, 2'd0);
        drive(1, 1'b0, 32'h0, 5'd0, 2'd0);
        check("mid_regrant_owner", 32'(owner), 32'd0);
        tick();
        check("mid_regrant_data", rsp0_data, 32'h0000_0002);
        tick();
        $display("op reset: mid-op reset discarded result, regrant to req0 -> 00000002");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
